// File: rtl/pb_field_walker_if.sv
// rtl/pb_field_walker_if.sv - message-line input and field-record output bus of the protobuf walker
// The walker sits on the slave side; the message source and record sink sit on the master side.
interface pb_field_walker_if #(
  parameter int LINE_SIZE = 512,
  parameter int OFF_W     = 32
);
  logic                 start;
  logic [OFF_W-1:0]     msg_len;
  logic                 line_valid;
  logic                 line_ready;
  logic [LINE_SIZE-1:0] line_data;
  logic                 field_valid;
  logic                 field_ready;
  logic [60:0]          field_id;
  logic [2:0]           wire_type;
  logic [OFF_W-1:0]     field_offset;
  logic [OFF_W-1:0]     field_len;
  logic                 busy;
  logic                 done;
  logic                 error;
  logic [1:0]           err_code;

  modport slave (
    input  start, msg_len, line_valid, line_data, field_ready,
    output line_ready, field_valid, field_id, wire_type, field_offset, field_len,
           busy, done, error, err_code
  );

  modport master (
    output start, msg_len, line_valid, line_data, field_ready,
    input  line_ready, field_valid, field_id, wire_type, field_offset, field_len,
           busy, done, error, err_code
  );
endinterface

// File: rtl/pb_field_walker.sv
// rtl/pb_field_walker.sv - byte-serial protobuf wire-format walker emitting one record per field
// Message byte k lives in line k/NB at byte k%NB, so the in-line index is the low bits of the position.
module pb_field_walker #(
  parameter int LINE_SIZE  = 512,
  parameter int OFF_W      = 32,
  parameter int MAX_VARINT = 10
) (
  input logic          clk,
  input logic          rst,
  pb_field_walker_if.slave bus
);
  localparam int NB    = LINE_SIZE / 8;
  localparam int IDX_W = (NB > 1) ? $clog2(NB) : 1;
  localparam int CNT_W = $clog2(MAX_VARINT + 1);

  typedef enum logic [2:0] {IDLE, TAG, LEN, SKIP, EMIT, DRAIN, FIN} state_t;

  state_t               state_q, state_d;
  logic                 buf_full_q, buf_full_d;
  logic [LINE_SIZE-1:0] buf_data_q, buf_data_d;
  logic [OFF_W-1:0]     pos_q, pos_d;
  logic [OFF_W-1:0]     len_q, len_d;
  logic [63:0]          tag_q, tag_d;
  logic [OFF_W-1:0]     acc_q, acc_d;
  logic [CNT_W-1:0]     vcnt_q, vcnt_d;
  logic [OFF_W-1:0]     skip_rem_q, skip_rem_d;
  logic                 skip_var_q, skip_var_d;
  logic                 fv_q, fv_d;
  logic [60:0]          fid_q, fid_d;
  logic [2:0]           fwt_q, fwt_d;
  logic [OFF_W-1:0]     foff_q, foff_d;
  logic [OFF_W-1:0]     flen_q, flen_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 err_q, err_d;
  logic [1:0]           ecode_q, ecode_d;

  logic [IDX_W-1:0]     idx;
  logic [7:0]           cur_byte;
  logic [OFF_W-1:0]     pos_inc;
  logic                 eom_inc;
  logic                 line_end_inc;
  logic [CNT_W-1:0]     vcnt_inc;
  logic                 ovf;
  logic [63:0]          chunk;
  logic [63:0]          tag_acc;
  logic [OFF_W-1:0]     len_acc;
  logic [OFF_W-1:0]     msg_left;
  logic [OFF_W-1:0]     line_left;
  logic [OFF_W-1:0]     step;
  logic [OFF_W-1:0]     pos_step;
  logic                 free_step;
  logic                 consume1;
  logic                 raise;
  logic [1:0]           raise_code;
  logic                 line_ready;

  assign line_ready = busy_q & ~buf_full_q;

  always_comb begin
    idx          = pos_q[IDX_W-1:0];
    cur_byte     = buf_data_q[{idx, 3'b000} +: 8];
    pos_inc      = pos_q + 1'b1;
    eom_inc      = (pos_inc == len_q);
    line_end_inc = (idx == IDX_W'(NB - 1));
    vcnt_inc     = vcnt_q + 1'b1;
    ovf          = cur_byte[7] && (vcnt_inc == CNT_W'(MAX_VARINT));
    chunk        = 64'(cur_byte[6:0]) << (7 * vcnt_q);
    tag_acc      = tag_q | chunk;
    len_acc      = acc_q | chunk[OFF_W-1:0];
    msg_left     = len_q - pos_q;
    line_left    = OFF_W'(NB) - OFF_W'(idx);
    step         = skip_rem_q;
    if (line_left < step) step = line_left;
    if (msg_left < step) step = msg_left;
    pos_step     = pos_q + step;
    free_step    = ((OFF_W'(idx) + step) == OFF_W'(NB)) || (pos_step == len_q);

    state_d    = state_q;
    buf_full_d = buf_full_q;
    buf_data_d = buf_data_q;
    pos_d      = pos_q;
    len_d      = len_q;
    tag_d      = tag_q;
    acc_d      = acc_q;
    vcnt_d     = vcnt_q;
    skip_rem_d = skip_rem_q;
    skip_var_d = skip_var_q;
    fid_d      = fid_q;
    fwt_d      = fwt_q;
    foff_d     = foff_q;
    flen_d     = flen_q;
    err_d      = err_q;
    ecode_d    = ecode_q;
    consume1   = 1'b0;
    raise      = 1'b0;
    raise_code = 2'd0;

    if (bus.line_valid && line_ready) begin
      buf_data_d = bus.line_data;
      buf_full_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          len_d   = bus.msg_len;
          pos_d   = '0;
          err_d   = 1'b0;
          ecode_d = 2'd0;
          tag_d   = '0;
          vcnt_d  = '0;
          state_d = (bus.msg_len == '0) ? FIN : TAG;
        end
      end
      TAG: begin
        if (buf_full_q) begin
          consume1 = 1'b1;
          tag_d    = tag_acc;
          vcnt_d   = vcnt_inc;
          if (cur_byte[7]) begin
            if (ovf) begin
              raise = 1'b1; raise_code = 2'd2;
            end else if (eom_inc) begin
              raise = 1'b1; raise_code = 2'd3;
            end
          end else begin
            fid_d      = tag_acc[63:3];
            fwt_d      = tag_acc[2:0];
            foff_d     = pos_inc;
            acc_d      = '0;
            vcnt_d     = '0;
            skip_var_d = 1'b0;
            case (tag_acc[2:0])
              3'd0: begin state_d = SKIP; skip_var_d = 1'b1; end
              3'd1: begin state_d = SKIP; skip_rem_d = OFF_W'(8); flen_d = OFF_W'(8); end
              3'd5: begin state_d = SKIP; skip_rem_d = OFF_W'(4); flen_d = OFF_W'(4); end
              3'd2: state_d = LEN;
              default: begin raise = 1'b1; raise_code = 2'd1; end
            endcase
            // Every legal wire type needs at least one more byte after the tag.
            if (!raise && eom_inc) begin
              raise = 1'b1; raise_code = 2'd3;
            end
          end
        end
      end
      LEN: begin
        if (buf_full_q) begin
          consume1 = 1'b1;
          acc_d    = len_acc;
          vcnt_d   = vcnt_inc;
          if (cur_byte[7]) begin
            if (ovf) begin
              raise = 1'b1; raise_code = 2'd2;
            end else if (eom_inc) begin
              raise = 1'b1; raise_code = 2'd3;
            end
          end else begin
            foff_d     = pos_inc;
            skip_rem_d = len_acc;
            flen_d     = len_acc;
            if (len_acc == '0) begin
              state_d = EMIT;
            end else if (eom_inc) begin
              raise = 1'b1; raise_code = 2'd3;
            end else begin
              state_d = SKIP;
            end
          end
        end
      end
      SKIP: begin
        if (buf_full_q) begin
          if (skip_var_q) begin
            consume1 = 1'b1;
            vcnt_d   = vcnt_inc;
            if (cur_byte[7]) begin
              if (ovf) begin
                raise = 1'b1; raise_code = 2'd2;
              end else if (eom_inc) begin
                raise = 1'b1; raise_code = 2'd3;
              end
            end else begin
              flen_d  = OFF_W'(vcnt_inc);
              state_d = EMIT;
            end
          end else begin
            // Counted payloads move in bulk, so a full interior line goes in one cycle.
            pos_d      = pos_step;
            skip_rem_d = skip_rem_q - step;
            if (free_step) buf_full_d = 1'b0;
            if (skip_rem_q == step) begin
              state_d = EMIT;
            end else if (pos_step == len_q) begin
              raise = 1'b1; raise_code = 2'd3;
            end
          end
        end
      end
      EMIT: begin
        if (bus.field_ready) begin
          state_d = (pos_q < len_q) ? TAG : FIN;
          tag_d   = '0;
          vcnt_d  = '0;
        end
      end
      DRAIN: begin
        if (pos_q >= len_q) begin
          state_d = FIN;
        end else if (buf_full_q) begin
          pos_d      = pos_q + ((line_left < msg_left) ? line_left : msg_left);
          buf_full_d = 1'b0;
        end
      end
      FIN: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (consume1) begin
      pos_d = pos_inc;
      if (line_end_inc || eom_inc) buf_full_d = 1'b0;
    end

    if (raise) begin
      err_d   = 1'b1;
      ecode_d = raise_code;
      state_d = DRAIN;
    end

    busy_d = (state_d != IDLE) && (state_d != FIN);
    done_d = (state_d == FIN);
    fv_d   = (state_d == EMIT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      buf_full_q <= 1'b0;
      buf_data_q <= '0;
      pos_q      <= '0;
      len_q      <= '0;
      tag_q      <= '0;
      acc_q      <= '0;
      vcnt_q     <= '0;
      skip_rem_q <= '0;
      skip_var_q <= 1'b0;
      fv_q       <= 1'b0;
      fid_q      <= '0;
      fwt_q      <= '0;
      foff_q     <= '0;
      flen_q     <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      ecode_q    <= 2'd0;
    end else begin
      state_q    <= state_d;
      buf_full_q <= buf_full_d;
      buf_data_q <= buf_data_d;
      pos_q      <= pos_d;
      len_q      <= len_d;
      tag_q      <= tag_d;
      acc_q      <= acc_d;
      vcnt_q     <= vcnt_d;
      skip_rem_q <= skip_rem_d;
      skip_var_q <= skip_var_d;
      fv_q       <= fv_d;
      fid_q      <= fid_d;
      fwt_q      <= fwt_d;
      foff_q     <= foff_d;
      flen_q     <= flen_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
      ecode_q    <= ecode_d;
    end
  end

  assign bus.line_ready   = line_ready;
  assign bus.field_valid  = fv_q;
  assign bus.field_id     = fid_q;
  assign bus.wire_type    = fwt_q;
  assign bus.field_offset = foff_q;
  assign bus.field_len    = flen_q;
  assign bus.busy         = busy_q;
  assign bus.done         = done_q;
  assign bus.error        = err_q;
  assign bus.err_code     = ecode_q;
endmodule

// File: tb/tb_pb_field_walker.sv
// tb/tb_pb_field_walker.sv - scoreboard bench for the protobuf field walker
// Directed messages push expected records; a negedge monitor checks every presented record.
module tb_pb_field_walker;
  localparam int LS = 512;
  localparam int OW = 32;
  localparam int NB = LS / 8;

  typedef struct {
    logic [60:0]   id;
    logic [2:0]    wt;
    logic [OW-1:0] off;
    logic [OW-1:0] len;
  } rec_t;

  logic clk;
  logic rst;
  pb_field_walker_if #(.LINE_SIZE(LS), .OFF_W(OW)) bus ();

  pb_field_walker #(.LINE_SIZE(LS), .OFF_W(OW), .MAX_VARINT(10)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  rec_t       exp_q[$];
  logic [7:0] mem [0:1023];
  int         errors = 0;
  int         checks = 0;
  int         done_cnt = 0;
  int         lines_fed = 0;
  int         stall_left = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic void exp_rec(input logic [60:0] id, input logic [2:0] wt,
                                  input logic [OW-1:0] off, input logic [OW-1:0] len);
    rec_t r;
    r.id = id; r.wt = wt; r.off = off; r.len = len;
    exp_q.push_back(r);
  endfunction

  task automatic clear_mem();
    for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
  endtask

  always @(negedge clk) if (bus.done) done_cnt++;

  // Record sink: optionally withholds field_ready for a few cycles of a presented record.
  initial begin
    bus.field_ready = 1'b1;
    forever begin
      @(negedge clk);
      if (stall_left > 0 && bus.field_valid) begin
        bus.field_ready = 1'b0;
        stall_left--;
      end else begin
        bus.field_ready = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    #1;
    if (!rst && bus.field_valid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_record", 64'd1, 64'd0);
      end else begin
        chk("field_id", {3'b0, bus.field_id}, {3'b0, exp_q[0].id});
        chk("wire_type", {61'b0, bus.wire_type}, {61'b0, exp_q[0].wt});
        chk("field_offset", {32'b0, bus.field_offset}, {32'b0, exp_q[0].off});
        chk("field_len", {32'b0, bus.field_len}, {32'b0, exp_q[0].len});
        if (bus.field_ready) void'(exp_q.pop_front());
      end
    end
  end

  task automatic feed(input int nl);
    int guard;
    for (int l = 0; l < nl; l++) begin
      for (int k = 0; k < NB; k++) bus.line_data[8*k +: 8] = mem[l*NB + k];
      bus.line_valid = 1'b1;
      guard = 0;
      while (!bus.line_ready && bus.busy && guard < 3000) begin
        @(negedge clk);
        guard++;
      end
      if (guard >= 3000) chk("line_accept_timeout", 64'd0, 64'd1);
      if (!bus.line_ready) break;
      @(negedge clk);
      lines_fed++;
      bus.line_valid = 1'b0;
    end
    bus.line_valid = 1'b0;
  endtask

  task automatic run_msg(input int len, input int nl, input int exp_err);
    int guard;
    @(negedge clk);
    done_cnt  = 0;
    lines_fed = 0;
    bus.msg_len = OW'(len);
    bus.start   = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    fork
      feed(nl);
      begin
        guard = 0;
        while (!bus.done && guard < 3000) begin
          @(negedge clk);
          guard++;
        end
      end
    join
    chk("done_seen", {63'b0, bus.done}, 64'd1);
    chk("busy_at_done", {63'b0, bus.busy}, 64'd0);
    chk("error", {63'b0, bus.error}, (exp_err != 0) ? 64'd1 : 64'd0);
    chk("err_code", {62'b0, bus.err_code}, 64'(exp_err));
    repeat (3) @(negedge clk);
    chk("done_once", 64'(done_cnt), 64'd1);
    chk("lines_fed", 64'(lines_fed), 64'(nl));
    chk("records_left", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_line_ready"}, {63'b0, bus.line_ready}, 64'd0);
    chk({tag, "_field_valid"}, {63'b0, bus.field_valid}, 64'd0);
    chk({tag, "_busy"}, {63'b0, bus.busy}, 64'd0);
    chk({tag, "_done"}, {63'b0, bus.done}, 64'd0);
    chk({tag, "_error"}, {63'b0, bus.error}, 64'd0);
    chk({tag, "_err_code"}, {62'b0, bus.err_code}, 64'd0);
    chk({tag, "_rec"}, {3'b0, bus.field_id} | {61'b0, bus.wire_type} |
        {32'b0, bus.field_offset} | {32'b0, bus.field_len}, 64'd0);
  endtask

  task automatic load_msg1();
    clear_mem();
    mem[0] = 8'h08; mem[1] = 8'h96; mem[2] = 8'h01;
  endtask

  task automatic load_long();
    clear_mem();
    mem[0] = 8'h0A; mem[1] = 8'hC8; mem[2] = 8'h01;
    mem[203] = 8'h10; mem[204] = 8'h05;
  endtask

  initial begin
    rst = 1'b1;
    bus.start = 1'b0;
    bus.msg_len = '0;
    bus.line_valid = 1'b0;
    bus.line_data = '0;
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    rst = 1'b0;

    load_msg1();
    exp_rec(61'd1, 3'd0, 1, 2);
    run_msg(3, 1, 0);

    clear_mem();
    mem[0] = 8'h12; mem[1] = 8'h03; mem[2] = 8'h61; mem[3] = 8'h62; mem[4] = 8'h63;
    mem[5] = 8'h28; mem[6] = 8'h05; mem[7] = 8'h1D; mem[8] = 8'h00; mem[9] = 8'h00;
    exp_rec(61'd2, 3'd2, 2, 3);
    exp_rec(61'd5, 3'd0, 6, 1);
    run_msg(10, 1, 3);

    load_long();
    exp_rec(61'd1, 3'd2, 3, 200);
    exp_rec(61'd2, 3'd0, 204, 1);
    run_msg(205, 4, 0);

    clear_mem();
    mem[0] = 8'h0B;
    run_msg(130, 3, 1);

    clear_mem();
    for (int i = 0; i < 11; i++) mem[i] = 8'hFF;
    run_msg(11, 1, 2);

    clear_mem();
    mem[0] = 8'h12; mem[1] = 8'h05; mem[2] = 8'h61;
    run_msg(3, 1, 3);

    load_msg1();
    stall_left = 5;
    exp_rec(61'd1, 3'd0, 1, 2);
    run_msg(3, 1, 0);

    clear_mem();
    run_msg(0, 0, 0);

    load_long();
    @(negedge clk);
    bus.msg_len = OW'(205);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    feed(1);
    repeat (4) @(negedge clk);
    chk("mid_skip_busy", {63'b0, bus.busy}, 64'd1);
    rst = 1'b1;
    @(negedge clk);
    chk_all_zero("mid_reset");
    rst = 1'b0;

    load_msg1();
    exp_rec(61'd1, 3'd0, 1, 2);
    run_msg(3, 1, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
